// File: rtl/seq_divider8.sv
// seq_divider8: multi-cycle unsigned 8-bit restoring divider.
//
// Computes quotient = dividend / divisor and remainder = dividend % divisor
// by shift-and-subtract. It produces one quotient bit per clock over 8 CALC
// cycles, and the accept-to-done latency is 9 cycles. A zero divisor skips
// CALC. In that case the block reports quotient 8'hFF, remainder = dividend
// and div_by_zero = 1 one cycle after the operation is accepted.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   request a division (accepted only while idle)
//   dividend     in   [7:0] unsigned dividend, sampled on the accepting edge
//   divisor      in   [7:0] unsigned divisor, sampled on the accepting edge
//   busy         out  high while an operation is in CALC or DONE
//   done         out  one-cycle pulse, results valid from this cycle on
//   quotient     out  [7:0] result, held until the next completion
//   remainder    out  [7:0] result, held until the next completion
//   div_by_zero  out  set with done when the divisor was zero
module seq_divider8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] count, count_nxt;
  logic [7:0] p_reg, p_nxt;
  logic [7:0] q_reg, q_nxt;
  logic [7:0] dvsr_reg, dvsr_nxt;
  logic [7:0] quot_nxt, rem_nxt;
  logic       dbz_nxt;

  logic [8:0] trial;
  logic       fits;
  logic [7:0] diff;
  logic [7:0] p_step;
  logic [7:0] q_step;

  // One restoring step: shift {P,Q} left and trial-subtract the divisor.
  // The partial remainder always stays below the divisor, so P fits in
  // 8 bits. Only the 9-bit shifted value needs the extra bit. When the
  // subtraction fits, its true result is below the divisor, so an 8-bit
  // difference is exact.
  always_comb begin
    trial = {p_reg, q_reg[7]};
    fits  = (trial >= {1'b0, dvsr_reg});
    diff  = trial[7:0] - dvsr_reg;
    if (fits) begin
      p_step = diff;
      q_step = {q_reg[6:0], 1'b1};
    end else begin
      p_step = trial[7:0];
      q_step = {q_reg[6:0], 1'b0};
    end
  end

  // Next-state and datapath update. Every register holds by default.
  // The result registers are written only on entry to DONE.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    p_nxt     = p_reg;
    q_nxt     = q_reg;
    dvsr_nxt  = dvsr_reg;
    quot_nxt  = quotient;
    rem_nxt   = remainder;
    dbz_nxt   = div_by_zero;

    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == 8'd0) begin
            state_nxt = DONE;
            quot_nxt  = 8'hFF;
            rem_nxt   = dividend;
            dbz_nxt   = 1'b1;
          end else begin
            state_nxt = CALC;
            q_nxt     = dividend;
            dvsr_nxt  = divisor;
            p_nxt     = 8'd0;
            count_nxt = 3'd0;
          end
        end
      end
      CALC: begin
        p_nxt     = p_step;
        q_nxt     = q_step;
        count_nxt = count + 3'd1;
        if (count == 3'd7) begin
          state_nxt = DONE;
          quot_nxt  = q_step;
          rem_nxt   = p_step;
          dbz_nxt   = 1'b0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any in-flight operation
  // and clears the visible results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 3'd0;
      p_reg       <= 8'd0;
      q_reg       <= 8'd0;
      dvsr_reg    <= 8'd0;
      quotient    <= 8'd0;
      remainder   <= 8'd0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      p_reg       <= p_nxt;
      q_reg       <= q_nxt;
      dvsr_reg    <= dvsr_nxt;
      quotient    <= quot_nxt;
      remainder   <= rem_nxt;
      div_by_zero <= dbz_nxt;
    end
  end

  // The status outputs are decoded from the state register only.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider8.sv
// tb_seq_divider8: self-checking bench for seq_divider8.
// It runs directed cases and a randomized batch. Expected results come from
// plain integer division.
module tb_seq_divider8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_checks;
  int n_fail;

  seq_divider8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_output({tag, " busy"}, int'(busy), 0);
    check_output({tag, " done"}, int'(done), 0);
    check_output({tag, " quotient"}, int'(quotient), 0);
    check_output({tag, " remainder"}, int'(remainder), 0);
    check_output({tag, " div_by_zero"}, int'(div_by_zero), 0);
  endtask

  // Wait for done after an accepting edge. The caller is already #1 past
  // that edge. This task checks the latency, busy while waiting, the
  // results, and that the results hold after the pulse.
  task automatic wait_and_check(input string tag, input int a, input int b);
    int lat;
    int busy_ok;
    int exp_q;
    int exp_r;
    int exp_z;
    int exp_lat;
    if (b == 0) begin
      exp_q = 255;
      exp_r = a;
      exp_z = 1;
      exp_lat = 1;
    end else begin
      exp_q = a / b;
      exp_r = a % b;
      exp_z = 0;
      exp_lat = 9;
    end
    lat = 1;
    busy_ok = 1;
    while (!done && lat < 20) begin
      if (!busy) busy_ok = 0;
      tick();
      lat++;
    end
    check_output({tag, " latency"}, lat, exp_lat);
    check_output({tag, " busy during op"}, busy_ok, 1);
    check_output({tag, " busy at done"}, int'(busy), 1);
    check_output({tag, " quotient"}, int'(quotient), exp_q);
    check_output({tag, " remainder"}, int'(remainder), exp_r);
    check_output({tag, " div_by_zero"}, int'(div_by_zero), exp_z);
    tick();
    check_output({tag, " done pulse ends"}, int'(done), 0);
    check_output({tag, " busy falls"}, int'(busy), 0);
    check_output({tag, " quotient held"}, int'(quotient), exp_q);
    check_output({tag, " remainder held"}, int'(remainder), exp_r);
  endtask

  // Pulse start for one edge with the given operands, scramble the operand
  // inputs afterwards, then check the completed operation.
  task automatic apply_stimulus(input string tag, input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    wait_and_check(tag, int'(a), int'(b));
  endtask

  initial begin
    int seen_done;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    tick();
    tick();
    check_idle_zero("reset");
    rst_n = 1'b1;
    tick();

    apply_stimulus("200/7", 8'd200, 8'd7);
    apply_stimulus("255/1", 8'd255, 8'd1);
    apply_stimulus("5/9", 8'd5, 8'd9);
    apply_stimulus("255/255", 8'd255, 8'd255);
    apply_stimulus("0/3", 8'd0, 8'd3);
    apply_stimulus("77/0", 8'd77, 8'd0);
    apply_stimulus("10/3", 8'd10, 8'd3);

    // Zero divisor followed immediately by an accept two edges later.
    apply_stimulus("0/0", 8'd0, 8'd0);
    apply_stimulus("1/255", 8'd1, 8'd255);

    // Hold start high and change the operands during CALC. The first result
    // must use the operands from the accepting edge. The second operation
    // is accepted on the first edge in IDLE, which follows the edge that
    // ends DONE.
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    dividend = 8'd50;
    divisor  = 8'd5;
    wait_and_check("held start first", 200, 7);
    tick();
    check_output("held start second accepted", int'(busy), 1);
    wait_and_check("held start second", 50, 5);
    start = 1'b0;

    // Reset during the fourth CALC cycle.
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check_output("pre-reset busy", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_zero("mid-calc reset");
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen_done = 1;
      tick();
    end
    check_output("no done after reset", seen_done, 0);
    apply_stimulus("100/10", 8'd100, 8'd10);

    // start and reset on the same edge: reset wins.
    dividend = 8'd9;
    divisor  = 8'd2;
    start    = 1'b1;
    rst_n    = 1'b0;
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    check_output("reset beats start busy", int'(busy), 0);
    tick();
    check_output("reset beats start busy later", int'(busy), 0);
    check_output("reset beats start done", int'(done), 0);

    // Randomized operands against the integer reference. Roughly one in
    // sixteen operations uses a zero divisor.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rb = 8'd0;
      apply_stimulus($sformatf("rand %0d/%0d", ra, rb), ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
